// File: rtl/pipe_control_unit.sv
// Pipelined control unit: ID decode, ID/EX/MEM/WB control bundle, load-use and
// redirect hazard handling, and start/done sequencing of multi-cycle channels.
module pipe_control_unit #(
  parameter int          REG_AW     = 5,
  parameter int          MC_CH      = 2,
  parameter logic [3:0]  MC_OP_BASE = 4'hC,
  parameter logic [1:0]  LOAD_RES   = 2'b01
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [3:0]        id_op,
  input  logic [2:0]        id_funct3,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              ex_taken,
  input  logic [MC_CH-1:0]  mc_done,
  output logic [MC_CH-1:0]  mc_start,
  output logic              mc_busy,
  output logic              stall_id,
  output logic              flush_ifid,
  output logic [3:0]        ex_aluctrl,
  output logic              ex_alusrc,
  output logic              ex_a2src,
  output logic [REG_AW-1:0] ex_rd,
  output logic              mem_memwrite,
  output logic [1:0]        mem_be,
  output logic [REG_AW-1:0] mem_rd,
  output logic              wb_regwrite,
  output logic [1:0]        wb_resmux,
  output logic [REG_AW-1:0] wb_rd
);

  typedef struct packed {
    logic              regwrite;
    logic              memwrite;
    logic              branch;
    logic              jump;
    logic              alusrc;
    logic              a2src;
    logic              is_mc;
    logic [1:0]        mc_ch;
    logic [1:0]        resmux;
    logic [1:0]        be;
    logic [3:0]        aluctrl;
    logic [REG_AW-1:0] rd;
  } ex_t;

  typedef struct packed {
    logic              regwrite;
    logic              memwrite;
    logic [1:0]        be;
    logic [1:0]        resmux;
    logic [REG_AW-1:0] rd;
  } mem_t;

  typedef struct packed {
    logic              regwrite;
    logic [1:0]        resmux;
    logic [REG_AW-1:0] rd;
  } wb_t;

  typedef enum logic {IDLE, BUSY} st_t;

  ex_t  dec, ex_q, ex_d;
  mem_t mem_q, mem_d;
  wb_t  wb_q, wb_d;
  logic v_ex_q, v_ex_d, v_mem_q, v_mem_d, v_wb_q, v_wb_d;
  st_t  st_q, st_d;
  logic [MC_CH-1:0] ch_oh_q, ch_oh_d, ex_oh;
  logic [3:0] mc_off;
  logic redirect, load_use, mc_go, mc_stall;

  // Decode table: 0 R-alu, 1 I-alu, 2 load, 3 store, 4 branch, 5 jal, 6 lui,
  // MC_OP_BASE+k multi-cycle channel k; anything else is a bubble.
  always_comb begin
    dec    = '0;
    mc_off = id_op - MC_OP_BASE;
    if (id_valid) begin
      dec.rd = id_rd;
      case (id_op)
        4'h0: begin dec.regwrite = 1'b1; dec.aluctrl = {1'b0, id_funct3}; end
        4'h1: begin dec.regwrite = 1'b1; dec.alusrc = 1'b1; dec.aluctrl = {1'b0, id_funct3}; end
        4'h2: begin dec.regwrite = 1'b1; dec.alusrc = 1'b1; dec.resmux = LOAD_RES; dec.be = id_funct3[1:0]; end
        4'h3: begin dec.memwrite = 1'b1; dec.alusrc = 1'b1; dec.be = id_funct3[1:0]; end
        4'h4: begin dec.branch = 1'b1; dec.aluctrl = {1'b1, id_funct3}; end
        4'h5: begin dec.jump = 1'b1; dec.regwrite = 1'b1; dec.a2src = 1'b1; dec.resmux = 2'b10; end
        4'h6: begin dec.regwrite = 1'b1; dec.alusrc = 1'b1; dec.aluctrl = 4'hF; end
        default: begin
          if (id_op >= MC_OP_BASE && int'(mc_off) < MC_CH) begin
            dec.is_mc    = 1'b1;
            dec.mc_ch    = 2'(mc_off);
            dec.regwrite = 1'b1;
            dec.resmux   = 2'b11;
          end else begin
            dec.rd = '0;
          end
        end
      endcase
    end
  end

  always_comb begin
    redirect = v_ex_q & ((ex_q.branch & ex_taken) | ex_q.jump);
    load_use = id_valid & v_ex_q & (ex_q.resmux == LOAD_RES) & (ex_q.rd != '0) &
               ((ex_q.rd == id_rs1) | (ex_q.rd == id_rs2));
    ex_oh    = MC_CH'(1) << ex_q.mc_ch;
    mc_go    = (st_q == IDLE) & v_ex_q & ex_q.is_mc;
    // Done is only honoured from the channel latched at start.
    mc_stall = mc_go | ((st_q == BUSY) & ~|(mc_done & ch_oh_q));

    st_d    = st_q;
    ch_oh_d = ch_oh_q;
    if (mc_go) begin
      st_d    = BUSY;
      ch_oh_d = ex_oh;
    end else if (st_q == BUSY && !mc_stall) begin
      st_d    = IDLE;
      ch_oh_d = '0;
    end

    ex_d   = ex_q;
    v_ex_d = v_ex_q;
    if (!mc_stall) begin
      if (redirect | load_use) begin
        ex_d   = '0;
        v_ex_d = 1'b0;
      end else begin
        ex_d   = dec;
        v_ex_d = id_valid;
      end
    end

    mem_d   = '0;
    v_mem_d = 1'b0;
    if (!mc_stall) begin
      mem_d   = '{regwrite: ex_q.regwrite, memwrite: ex_q.memwrite, be: ex_q.be,
                  resmux: ex_q.resmux, rd: ex_q.rd};
      v_mem_d = v_ex_q;
    end

    wb_d   = '{regwrite: mem_q.regwrite, resmux: mem_q.resmux, rd: mem_q.rd};
    v_wb_d = v_mem_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q    <= '0;
      mem_q   <= '0;
      wb_q    <= '0;
      v_ex_q  <= 1'b0;
      v_mem_q <= 1'b0;
      v_wb_q  <= 1'b0;
      st_q    <= IDLE;
      ch_oh_q <= '0;
    end else begin
      ex_q    <= ex_d;
      mem_q   <= mem_d;
      wb_q    <= wb_d;
      v_ex_q  <= v_ex_d;
      v_mem_q <= v_mem_d;
      v_wb_q  <= v_wb_d;
      st_q    <= st_d;
      ch_oh_q <= ch_oh_d;
    end
  end

  assign mc_start     = mc_go ? ex_oh : '0;
  assign mc_busy      = (st_q == BUSY);
  assign stall_id     = mc_stall | (load_use & ~redirect);
  assign flush_ifid   = redirect;
  assign ex_aluctrl   = ex_q.aluctrl;
  assign ex_alusrc    = ex_q.alusrc;
  assign ex_a2src     = ex_q.a2src;
  assign ex_rd        = ex_q.rd;
  assign mem_memwrite = v_mem_q & mem_q.memwrite;
  assign mem_be       = mem_q.be;
  assign mem_rd       = mem_q.rd;
  assign wb_regwrite  = v_wb_q & wb_q.regwrite & (wb_q.rd != '0);
  assign wb_resmux    = wb_q.resmux;
  assign wb_rd        = wb_q.rd;

endmodule
